// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl
// Instruction-sequencing controller for the 8-bit toy CPU. Every instruction
// takes eight clocks: four fetch states (S0-S3) and four execute states
// (S4-S7). The block drives all datapath and memory strobes as a
// combinational decode of the current state, the opcode and the registered
// zero flag. HLT parks the controller in HALTED until reset.
//
// Ports
//   clk          in   single clock, rising-edge active
//   rst          in   synchronous active-high reset
//   opcode[2:0]  in   IR[15:13], valid from S2 onward
//   zero         in   accumulator == 0 flag from the ALU
//   fetch        out  address mux selects PC (S0-S3)
//   rd           out  memory read strobe
//   wr           out  memory write strobe
//   inc_pc       out  PC += 1 on next edge
//   load_pc      out  PC <= IR[12:0] on next edge
//   load_ir      out  IR captures data bus byte on next edge
//   load_acc     out  accumulator captures ALU result on next edge
//   datactl_ena  out  drive accumulator onto the data bus
//   halt         out  halted indication
// -----------------------------------------------------------------------------
module cpu_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       fetch,
    output logic       rd,
    output logic       wr,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_S0     = 4'd1,
        ST_S1     = 4'd2,
        ST_S2     = 4'd3,
        ST_S3     = 4'd4,
        ST_S4     = 4'd5,
        ST_S5     = 4'd6,
        ST_S6     = 4'd7,
        ST_S7     = 4'd8,
        ST_HALTED = 4'd9
    } state_t;

    state_t state_q, state_d;
    logic   zero_q,  zero_d;

    // Opcodes that read an operand from memory and feed the accumulator.
    function automatic logic is_mem_read(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_LDA: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // State and zero-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic; zero is sampled only on leaving S3 so SKZ sees a
    // flag that cannot change under it during the execute phase.
    always_comb begin
        state_d = state_q;
        zero_d  = zero_q;
        case (state_q)
            ST_RST:    state_d = ST_S0;
            ST_S0:     state_d = ST_S1;
            ST_S1:     state_d = ST_S2;
            ST_S2:     state_d = ST_S3;
            ST_S3: begin
                zero_d = zero;
                if (opcode == OP_HLT) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_S4;
                end
            end
            ST_S4:     state_d = ST_S5;
            ST_S5:     state_d = ST_S6;
            ST_S6:     state_d = ST_S7;
            ST_S7:     state_d = ST_S0;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RST;
        endcase
    end

    // Strobe decode of state, opcode and captured zero flag.
    always_comb begin
        fetch       = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_ir     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        case (state_q)
            ST_S0, ST_S1: begin
                // High byte in S0, low byte in S1; PC steps past each.
                fetch   = 1'b1;
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
            end
            ST_S2: begin
                fetch = 1'b1;
            end
            ST_S3: begin
                fetch = 1'b1;
                if (opcode == OP_HLT) begin
                    halt = 1'b1;
                end else begin
                    halt = 1'b0;
                end
            end
            ST_S4: begin
                if (is_mem_read(opcode)) begin
                    rd = 1'b1;
                end else begin
                    case (opcode)
                        OP_STO:  datactl_ena = 1'b1;
                        OP_JMP:  load_pc     = 1'b1;
                        OP_SKZ:  inc_pc      = zero_q;
                        default: rd          = 1'b0;
                    endcase
                end
            end
            ST_S5: begin
                if (is_mem_read(opcode)) begin
                    rd       = 1'b1;
                    load_acc = 1'b1;
                end else begin
                    case (opcode)
                        OP_STO: begin
                            // Write sits inside a bus window opened in S4
                            // and closed after S6.
                            datactl_ena = 1'b1;
                            wr          = 1'b1;
                        end
                        OP_JMP:  load_pc = 1'b1;
                        OP_SKZ:  inc_pc  = zero_q;
                        default: rd      = 1'b0;
                    endcase
                end
            end
            ST_S6: begin
                if (opcode == OP_STO) begin
                    datactl_ena = 1'b1;
                end else begin
                    datactl_ena = 1'b0;
                end
            end
            ST_HALTED: begin
                halt = 1'b1;
            end
            default: begin
                fetch = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl
// Directed and randomized instruction sequences for cpu_ctrl, checked every
// cycle against a reference model that tracks the instruction's clock index,
// the halted condition and the zero flag sampled at the fourth clock.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       fetch, rd, wr, inc_pc, load_pc, load_ir, load_acc, datactl_ena, halt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: cycle index within the instruction
    // (-1 = reset, 0..7 = clock of instruction, 8 = halted).
    int   m_phase = -1;
    logic m_zq    = 1'b0;
    bit   m_valid = 1'b0;
    int   inc_cnt = 0;

    cpu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .zero        (zero),
        .fetch       (fetch),
        .rd          (rd),
        .wr          (wr),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_ir     (load_ir),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected strobes {fetch,rd,wr,inc_pc,load_pc,load_ir,load_acc,datactl_ena,halt}
    function automatic logic [8:0] model_out(input int ph, input logic [2:0] op, input logic zq);
        logic f, r, w, ip, lp, li, la, de, h;
        bit   memop;
        f = 1'b0; r = 1'b0; w = 1'b0; ip = 1'b0; lp = 1'b0;
        li = 1'b0; la = 1'b0; de = 1'b0; h = 1'b0;
        memop = (op >= 3'd2) && (op <= 3'd5);
        if (ph == 8) h = 1'b1;
        if (ph >= 0 && ph <= 3) f = 1'b1;
        if (ph == 0 || ph == 1) begin r = 1'b1; li = 1'b1; ip = 1'b1; end
        if (ph == 3 && op == 3'd0) h = 1'b1;
        if (ph == 4 || ph == 5) begin
            if (memop) r = 1'b1;
            if (memop && ph == 5) la = 1'b1;
            if (op == 3'd6) de = 1'b1;
            if (op == 3'd6 && ph == 5) w = 1'b1;
            if (op == 3'd7) lp = 1'b1;
            if (op == 3'd1 && zq) ip = 1'b1;
        end
        if (ph == 6 && op == 3'd6) de = 1'b1;
        return {f, r, w, ip, lp, li, la, de, h};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h phase=%0d", tag, obs, expv, m_phase);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, then advance model.
    task automatic step(input logic r, input logic [2:0] op, input logic z);
        logic [8:0] obs;
        @(negedge clk);
        rst = r; opcode = op; zero = z;
        #1;
        obs = {fetch, rd, wr, inc_pc, load_pc, load_ir, load_acc, datactl_ena, halt};
        if (m_valid) begin
            chk("strobes", {23'd0, obs}, {23'd0, model_out(m_phase, op, m_zq)});
            if (m_phase == 0) inc_cnt = 0;
            if (m_phase >= 0 && m_phase <= 7) inc_cnt += int'(inc_pc);
            if (m_phase == 7)
                chk("inc_pc_count", inc_cnt, (op == 3'd1 && m_zq) ? 4 : 2);
        end
        @(posedge clk);
        m_valid = 1'b1;
        if (r) begin
            m_phase = -1;
            m_zq    = 1'b0;
        end else if (m_phase == -1) begin
            m_phase = 0;
        end else if (m_phase == 3) begin
            m_zq    = z;
            m_phase = (op == 3'd0) ? 8 : 4;
        end else if (m_phase == 7) begin
            m_phase = 0;
        end else if (m_phase != 8) begin
            m_phase = m_phase + 1;
        end
    endtask

    // Opcode is garbage during the byte fetches; zpat bit i is zero at clock i.
    task automatic instr(input logic [2:0] op, input logic [7:0] zpat);
        for (int i = 0; i < 8; i++)
            step(1'b0, (i < 2) ? 3'($urandom_range(0, 7)) : op, zpat[i]);
    endtask

    task automatic do_reset();
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; opcode = 3'd0; zero = 1'b0;
        do_reset();
        instr(3'd5, 8'h00);                 // LDA
        instr(3'd6, 8'hFF);                 // STO
        instr(3'd1, 8'b0000_1000);          // SKZ taken
        instr(3'd1, 8'b1111_0000);          // SKZ, zero only after sampling
        instr(3'd7, 8'h00);                 // JMP
        instr(3'd2, 8'h5A);                 // ADD
        instr(3'd3, 8'hA5);                 // AND
        instr(3'd4, 8'h0F);                 // XOR

        // Reset during the STO write cycle.
        for (int i = 0; i < 5; i++)
            step(1'b0, (i < 2) ? 3'd0 : 3'd6, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        step(1'b0, 3'd6, 1'b0);
        instr(3'd6, 8'h00);

        // HLT, hold 20 cycles, then reset out of HALTED.
        instr(3'd0, 8'h00);
        for (int i = 0; i < 20; i++)
            step(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        step(1'b1, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        instr(3'd5, 8'h00);

        // Randomized instruction stream, occasionally halting.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd1;
            instr(op, 8'($urandom));
            if (op == 3'd0) begin
                for (int i = 0; i < 3; i++)
                    step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
                step(1'b1, 3'd0, 1'b0);
                step(1'b0, 3'd0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
